// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine with architectural HI/LO registers.
// One shift-add (multiply) or restoring-divide step per cycle; results land in HI/LO at FIN.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] step_mul;
  logic [2*WIDTH-1:0] step_div;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Add multiplicand into the upper half when the current multiplier bit is set, then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] h,
                                                  input logic [WIDTH-1:0] l,
                                                  input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, h} + (l[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum, l[WIDTH-1:1]};
  endfunction

  // Restoring step: shift the next dividend bit into the remainder and keep the trial
  // subtraction only when it does not borrow; the shifted-out sh[WIDTH] is zero on borrow.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] h,
                                                  input logic [WIDTH-1:0] l,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    logic           borrow;
    sh     = {h, l[WIDTH-1]};
    diff   = sh - {1'b0, dvs};
    borrow = (sh < {1'b0, dvs});
    return {(borrow ? sh[WIDTH-1:0] : diff[WIDTH-1:0]), l[WIDTH-2:0], ~borrow};
  endfunction

  assign abs_a    = abs_val(A, is_signed);
  assign abs_b    = abs_val(B, is_signed);
  assign step_mul = mul_step(acc_hi, acc_lo, opb);
  assign step_div = div_step(acc_hi, acc_lo, opb);
  assign prod_neg = {(2*WIDTH){1'b0}} - {acc_hi, acc_lo};
  assign busy     = (state != IDLE);

  // Sign fixup; divide-by-zero forces an all-ones quotient and leaves the dividend as remainder.
  always_comb begin
    fin_hi = acc_hi;
    fin_lo = acc_lo;
    if (!op_div) begin
      if (neg_q) begin
        fin_hi = prod_neg[2*WIDTH-1:WIDTH];
        fin_lo = prod_neg[WIDTH-1:0];
      end
    end else begin
      fin_hi = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
      if (b_zero) begin
        fin_lo = {WIDTH{1'b1}};
      end else if (neg_q) begin
        fin_lo = ~acc_lo + WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: cnt <= cnt + CNT_W'(1);
        FIN: begin
          hi          <= fin_hi;
          lo          <= fin_lo;
          div_by_zero <= op_div & b_zero;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; they are fully reloaded on every accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_div <= op;
      neg_q  <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      neg_r  <= is_signed & A[WIDTH-1];
      b_zero <= (B == '0);
      acc_hi <= '0;
      acc_lo <= op ? abs_a : abs_b;
      opb    <= op ? abs_b : abs_a;
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= op_div ? step_div : step_mul;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: expected HI/LO/flag queued at start, compared at done.
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         op;
  logic         is_signed;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .is_signed(is_signed),
    .A(A), .B(B), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t  sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    t0      = 0;
  string cur     = "init";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h, expected %h", cur, tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sbv;
    int          ia, ib;
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    if (!o) begin
      if (s) begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = 64'(sa * sbv);
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.lo  = '1;
      e.hi  = a;
      e.dbz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'h0;
    end else if (s) begin
      ia   = $signed(a);
      ib   = $signed(b);
      e.lo = 32'(ia / ib);
      e.hi = 32'(ia % ib);
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic begin_op(input logic o, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit push);
    @(negedge clk);
    start = 1'b1; op = o; is_signed = s; A = a; B = b;
    if (push) sb_q.push_back(model(o, s, a, b));
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic wait_done();
    while (!done && (cyc - t0) < 100) begin
      @(posedge clk);
      #1;
    end
    check("latency", 64'(cyc - t0), 64'd33);
  endtask

  task automatic run_op(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    begin_op(o, s, a, b, 1'b1);
    wait_done();
  endtask

  initial begin
    logic [W-1:0] ra, rb, hi_prev;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; is_signed = 1'b0;
    A = '0; B = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    #12;
    cur = "reset";
    check("busy", 64'(busy), 64'd0);
    check("done", 64'(done), 64'd0);
    check("dbz", 64'(div_by_zero), 64'd0);
    check("hi", 64'(hi), 64'd0);
    check("lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    cur = "umul_ffff_x2";
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    check("lo_const", 64'(lo), 64'hFFFF_FFFE);
    check("hi_const", 64'(hi), 64'h1);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);

    cur = "smul_m3x7";
    run_op(1'b0, 1'b1, -32'sd3, 32'd7);
    cur = "sdiv_m7d2";
    run_op(1'b1, 1'b1, -32'sd7, 32'd2);
    check("lo_const", 64'(lo), 64'hFFFF_FFFD);
    cur = "udiv_7d2";
    run_op(1'b1, 1'b0, 32'd7, 32'd2);
    cur = "div_by_zero";
    run_op(1'b1, 1'b0, 32'h1234, 32'd0);
    cur = "mul_clears_dbz";
    run_op(1'b0, 1'b0, 32'd2, 32'd3);
    cur = "sdiv_overflow";
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    cur = "sdiv_by_zero_neg";
    run_op(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0);
    cur = "udiv_max";
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1);

    cur = "ignore_while_busy";
    begin_op(1'b0, 1'b1, 32'h1234_5678, -32'sd5, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_run", 64'(busy), 64'd1);
    start = 1'b1; op = 1'b1; A = 32'd99; B = 32'd7;
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done();

    cur = "mtlo_idle";
    hi_prev = hi;
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'h0000_A5A5;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("lo", 64'(lo), 64'h0000_A5A5);
    check("hi_kept", 64'(hi), 64'(hi_prev));

    cur = "mthi_mtlo_both";
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("hi", 64'(hi), 64'h5A5A_0F0F);
    check("lo", 64'(lo), 64'h5A5A_0F0F);

    cur = "rand";
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb);
    end

    cur = "reset_mid_div";
    begin_op(1'b1, 1'b0, 32'hCAFE_F00D, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("busy", 64'(busy), 64'd0);
    check("done", 64'(done), 64'd0);
    check("hi", 64'(hi), 64'd0);
    check("lo", 64'(lo), 64'd0);
    check("dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cur = "after_reset";
    run_op(1'b1, 1'b1, -32'sd100, 32'd7);

    repeat (3) @(posedge clk);
    #1;
    cur = "end";
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
